// File: rtl/slot_alloc_tracker.sv
// Busy/free tracker for NUM_SLOTS entries with WAYS allocate and free ports per cycle.
// Grant indices are decoded to one-hot, merged into the busy vector, and summarised as registered free status.
module slot_alloc_tracker #(
   parameter int NUM_SLOTS = 8,
   parameter int WAYS      = 2,
   parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [WAYS-1:0]                 alloc_valid,
   input  logic [WAYS*IDX_W-1:0]           alloc_idx,
   input  logic [WAYS-1:0]                 free_valid,
   input  logic [WAYS*IDX_W-1:0]           free_idx,
   output logic [NUM_SLOTS-1:0]            free_vec,
   output logic [IDX_W:0]                  free_count,
   output logic [$clog2(WAYS+1)-1:0]       avail,
   output logic                            full,
   output logic                            empty,
   output logic                            err_alloc,
   output logic                            err_free
);

   localparam int              AW        = $clog2(WAYS + 1);
   localparam logic [IDX_W:0]  SLOTS_C   = (IDX_W + 1)'(NUM_SLOTS);
   localparam logic [AW-1:0]   WAYS_C    = AW'(WAYS);
   localparam logic [AW-1:0]   AVAIL_RST = AW'((NUM_SLOTS < WAYS) ? NUM_SLOTS : WAYS);

   logic [NUM_SLOTS-1:0] busy_q, busy_d;
   logic [IDX_W:0]       count_q, count_d;
   logic [AW-1:0]        avail_q, avail_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic                 err_alloc_q, err_alloc_d;
   logic                 err_free_q, err_free_d;

   logic [NUM_SLOTS-1:0] alloc_oh, free_oh;
   logic                 alloc_bad, free_bad;
   logic [IDX_W-1:0]     a_idx, f_idx;

   // NOTE: every signal driven here gets a default before any branch, so no latches are inferred.
   always_comb begin
      alloc_oh  = '0;
      free_oh   = '0;
      alloc_bad = 1'b0;
      free_bad  = 1'b0;
      a_idx     = '0;
      f_idx     = '0;
      for (int w = 0; w < WAYS; w++) begin
         // Invalid ways never look at their index bits, so X on them cannot leak into state.
         if (alloc_valid[w]) begin
            a_idx = alloc_idx[w*IDX_W +: IDX_W];
            if ({1'b0, a_idx} >= SLOTS_C) alloc_bad = 1'b1;
            for (int s = 0; s < NUM_SLOTS; s++)
               if (a_idx == IDX_W'(s)) alloc_oh[s] = 1'b1;
         end
         if (free_valid[w]) begin
            f_idx = free_idx[w*IDX_W +: IDX_W];
            if ({1'b0, f_idx} >= SLOTS_C) free_bad = 1'b1;
            for (int s = 0; s < NUM_SLOTS; s++)
               if (f_idx == IDX_W'(s)) free_oh[s] = 1'b1;
         end
      end
      for (int i = 0; i < WAYS; i++) begin
         for (int j = i + 1; j < WAYS; j++) begin
            if (alloc_valid[i] && alloc_valid[j] &&
                alloc_idx[i*IDX_W +: IDX_W] == alloc_idx[j*IDX_W +: IDX_W])
               alloc_bad = 1'b1;
            if (free_valid[i] && free_valid[j] &&
                free_idx[i*IDX_W +: IDX_W] == free_idx[j*IDX_W +: IDX_W])
               free_bad = 1'b1;
         end
      end
      // Frees land first, so re-allocating a slot released this cycle is legal.
      if (|(alloc_oh & busy_q & ~free_oh)) alloc_bad = 1'b1;
      if (|(free_oh & ~busy_q))            free_bad  = 1'b1;
   end

   always_comb begin
      busy_d      = (busy_q & ~free_oh) | alloc_oh;
      err_alloc_d = err_alloc_q | alloc_bad;
      err_free_d  = err_free_q | free_bad;
      count_d     = '0;
      for (int s = 0; s < NUM_SLOTS; s++)
         count_d = count_d + {{IDX_W{1'b0}}, ~busy_d[s]};
      if (int'(count_d) >= WAYS) avail_d = WAYS_C;
      else                       avail_d = AW'(count_d);
      full_d  = (count_d == '0);
      empty_d = (count_d == SLOTS_C);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q      <= '0;
         count_q     <= SLOTS_C;
         avail_q     <= AVAIL_RST;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         err_alloc_q <= 1'b0;
         err_free_q  <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         count_q     <= count_d;
         avail_q     <= avail_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         err_alloc_q <= err_alloc_d;
         err_free_q  <= err_free_d;
      end
   end

   assign free_vec   = ~busy_q;
   assign free_count = count_q;
   assign avail      = avail_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign err_alloc  = err_alloc_q;
   assign err_free   = err_free_q;

endmodule

// File: doc/slot_alloc_tracker.md
Name: slot_alloc_tracker

Overview:
Tracks busy/free state of NUM_SLOTS entries (RS/ROB/freelist style) for a WAYS-wide superscalar pipeline. It is the decode end of the selector path. It consumes the encoded grant indices produced by the priority selector and encoder pair, and decodes them back to one-hot to mark slots busy. It also frees slots on retire/issue. Its registered free vector drives the selector's request input on the next cycle.

Parameters:
NUM_SLOTS, 8, number of tracked slots (≥2, need not be power of 2)
WAYS, 2, allocation and free ports per cycle
IDX_W, $clog2(NUM_SLOTS), slot index width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; clears all state
alloc_valid  in  WAYS  per-way allocate strobe
alloc_idx  in  WAYS*IDX_W  packed [WAYS-1:0][IDX_W-1:0]; slot index to allocate
free_valid  in  WAYS  per-way free strobe
free_idx  in  WAYS*IDX_W  packed [WAYS-1:0][IDX_W-1:0]; slot index to release
free_vec  out  NUM_SLOTS  registered; bit i=1 means slot i is free (selector req)
free_count  out  IDX_W+1  registered popcount of free_vec
avail  out  $clog2(WAYS+1)  min(free_count, WAYS): allocations legal next cycle
full  out  1  registered; free_count==0
empty  out  1  registered; free_count==NUM_SLOTS
err_alloc  out  1  sticky; illegal allocate seen
err_free  out  1  sticky; illegal free seen

Behaviour:
- Reset (reset=0, async): busy=0, free_vec=all ones, free_count=NUM_SLOTS, avail=min(NUM_SLOTS,WAYS), full=0, empty=1, err_alloc=0, err_free=0. These outputs hold while reset is low. Reset mid-operation discards all in-flight state; there is no partial update.
- Decode: each valid way produces a one-hot NUM_SLOTS vector. Ways are OR-combined into alloc_oh and free_oh.
- Update on posedge, one-cycle latency: busy_next = (busy & ~free_oh) | alloc_oh. All outputs derive from registered state only; there is no combinational input-to-output path.
- Frees take effect before allocates within a cycle. Allocating a slot freed the same cycle is legal and leaves the slot busy, with no error.
- err_alloc sets on any of:
  - alloc of a slot that is busy after the free is applied (busy & ~free_oh);
  - two valid alloc ways with equal index;
  - alloc_idx ≥ NUM_SLOTS.
- err_free sets on any of:
  - free of a currently free slot;
  - two valid free ways with equal index;
  - free_idx ≥ NUM_SLOTS.
- Error handling:
  - Both error flags are sticky until reset.
  - An out-of-range index is ignored for state.
  - Other illegal ops still apply per the busy_next equation.
- Invalid ways (valid=0) are fully ignored, including their idx bits (X-safe).
- free_count, full, empty and avail are computed from busy_next and registered, so they are coherent with free_vec every cycle.
- At full, allocates are errors and state is unchanged.
- At empty, frees are errors and state is unchanged.

Test Plan:
1. Reset, then idle → free_vec=8'hFF, free_count=8, avail=2, empty=1, full=0, no errors.
2. Cycle 1: alloc ways {0:idx0, 1:idx1}. Next cycle → free_vec=8'hFC, free_count=6, empty=0.
3. Allocate 2 per cycle for 4 cycles (idx 0–7). Then free idx3 and alloc idx3 in the same cycle. Expected: full=1 and free_count=0 after the 4th cycle; free_vec stays 8'h00 after the combined cycle; err_alloc=0, err_free=0.
4. With all slots free, alloc ways both idx5 → free_vec=8'hDF, err_alloc=1, still 1 after 3 idle cycles.
5. Free slot 2 while it is free → err_free=1, free_vec unchanged. With NUM_SLOTS=6, alloc idx7 → err_alloc=1, free_vec unchanged.
6. Assert reset asynchronously mid-cycle after scenario 3 → outputs return to reset values immediately, without waiting for a clock edge. Errors clear.
